// File: rtl/id_pipe_ctrl.sv
// id_pipe_ctrl
// Controls the IF/ID pipeline register in front of the instruction decoder.
// Holds one fetched instruction and its PC, runs the valid/allowin handshake
// with IF and EX, inserts bubbles for load-use hazards against the load
// currently in EX, kills the held instruction on a flush and counts the
// cycles lost to hazard stalls.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   resetn         synchronous active-low reset
//   if_valid       IF presents a valid instruction
//   if_inst        fetched instruction word
//   if_pc          PC of the fetched instruction
//   id_allowin     ID can accept from IF this cycle
//   ex_allowin     EX can accept from ID this cycle
//   ex_valid       EX holds a valid instruction
//   ex_mem_read    EX instruction is a load
//   ex_wreg        EX destination register
//   flush          exception/eret flush, kills the ID content
//   id_to_ex_valid ID presents a valid instruction to EX
//   id_inst        held instruction word
//   id_pc          held PC
//   id_bubble      held instruction is blocked by a load-use hazard
//   stall_cnt      saturating count of hazard-stall cycles
module id_pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic             id_allowin,
  input  logic             ex_allowin,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_wreg,
  input  logic             flush,
  output logic             id_to_ex_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  // The stall state is not stored: it is a FULL register whose hazard is
  // currently asserted, so only EMPTY/FULL needs a flop.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stateT;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stateT            r_state;
  stateT            w_nextState;
  logic             w_loadInst;
  logic [31:0]      r_inst;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_stallCnt;

  logic             w_valid;
  logic [5:0]       w_opcode;
  logic [5:0]       w_func;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic             w_usesRs;
  logic             w_usesRt;
  logic             w_hazard;
  logic             w_readyGo;
  logic             w_allowin;

  assign w_valid  = (r_state == ST_FULL);
  assign w_opcode = r_inst[31:26];
  assign w_rs     = r_inst[25:21];
  assign w_rt     = r_inst[20:16];
  assign w_func   = r_inst[5:0];

  // Source-register usage of the held instruction. J/JAL/LUI carry no rs
  // operand, and the immediate shifts reuse the rs field as padding.
  always_comb begin
    w_usesRs = 1'b1;
    w_usesRt = 1'b0;
    case (w_opcode)
      6'b000010, 6'b000011, 6'b001111: w_usesRs = 1'b0;
      6'b000000: begin
        w_usesRt = 1'b1;
        if (w_func == 6'b000000 || w_func == 6'b000010 || w_func == 6'b000011)
          w_usesRs = 1'b0;
      end
      6'b000100, 6'b000101, 6'b101011: w_usesRt = 1'b1;
      default: ;
    endcase
  end

  // A load in EX whose result feeds the held instruction forces a bubble;
  // $0 is never a real dependency.
  assign w_hazard = w_valid & ex_valid & ex_mem_read & (ex_wreg != 5'd0) &
                    ((w_usesRs & (w_rs == ex_wreg)) | (w_usesRt & (w_rt == ex_wreg)));

  assign w_readyGo      = ~w_hazard;
  assign w_allowin      = ~w_valid | (w_readyGo & ex_allowin);
  assign id_allowin     = w_allowin;
  assign id_to_ex_valid = w_valid & w_readyGo;
  assign id_bubble      = w_hazard;
  assign id_inst        = r_inst;
  assign id_pc          = r_pc;
  assign stall_cnt      = r_stallCnt;

  // Next-state: flush beats everything, then a normal IF->ID transfer,
  // otherwise the register holds (stall or back-pressure).
  always_comb begin
    w_nextState = r_state;
    w_loadInst  = 1'b0;
    if (flush) begin
      w_nextState = ST_EMPTY;
    end else if (w_allowin) begin
      w_nextState = if_valid ? ST_FULL : ST_EMPTY;
      w_loadInst  = if_valid;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_EMPTY;
    else         r_state <= w_nextState;
  end

  // Instruction/PC payload; left untouched on flush since it is dead then.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inst <= 32'd0;
      r_pc   <= RESET_PC;
    end else if (w_loadInst) begin
      r_inst <= if_inst;
      r_pc   <= if_pc;
    end
  end

  // Stall counter: a flushed stall is not a lost cycle of useful work, so
  // it is not counted. Saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stallCnt <= '0;
    end else if (w_hazard && !flush && r_stallCnt != CNT_MAX) begin
      r_stallCnt <= r_stallCnt + CNT_ONE;
    end
  end

endmodule
